// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction and data ports onto one memory port, one transaction outstanding
module mem_arbiter #(
  parameter logic fixed_priority = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic        imemory_ready,
  output logic [31:0] imemory_rdata,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic        dmemory_ready,
  output logic [31:0] dmemory_rdata,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic        memory_ready,
  input  logic [31:0] memory_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic pend_i_v, pend_d_v, pend_i_v_nxt, pend_d_v_nxt;
  logic [68:0] pend_i, pend_d, pend_i_nxt, pend_d_nxt, req, req_nxt;
  logic last_d, last_d_nxt;
  logic accept_i, accept_d, issue, win_d, issue_nxt, win_d_nxt;
  // last_d doubles as the owner of the outstanding transaction, since the owner is always the last grant
  always_comb begin
    accept_i = imemory_valid && !(pend_i_v || (state == BUSY && !last_d && !memory_ready));
    accept_d = dmemory_valid && !(pend_d_v || (state == BUSY && last_d && !memory_ready));
    issue = state == IDLE && (pend_i_v || pend_d_v);
    win_d = pend_d_v && (!pend_i_v || fixed_priority || !last_d);
  end
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: issue from IDLE, return on the memory response
  always_comb state_nxt = issue ? BUSY : (state == BUSY && memory_ready) ? IDLE : state;
  // next buffer contents, and the request the memory port will carry next cycle
  always_comb begin
    pend_i_v_nxt = accept_i || (pend_i_v && !(issue && !win_d));
    pend_d_v_nxt = accept_d || (pend_d_v && !(issue && win_d));
    pend_i_nxt = accept_i ? {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb} : pend_i;
    pend_d_nxt = accept_d ? {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb} : pend_d;
    last_d_nxt = issue ? win_d : last_d;
    issue_nxt = state_nxt == IDLE && (pend_i_v_nxt || pend_d_v_nxt);
    win_d_nxt = pend_d_v_nxt && (!pend_i_v_nxt || fixed_priority || !last_d_nxt);
    req_nxt = !issue_nxt ? '0 : win_d_nxt ? pend_d_nxt : pend_i_nxt;
  end
  // pending buffers, grant history and the registered memory request
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pend_i_v <= 1'b0;
      pend_d_v <= 1'b0;
      pend_i <= '0;
      pend_d <= '0;
      last_d <= 1'b0;
      memory_valid <= 1'b0;
      req <= '0;
    end else begin
      pend_i_v <= pend_i_v_nxt;
      pend_d_v <= pend_d_v_nxt;
      pend_i <= pend_i_nxt;
      pend_d <= pend_d_nxt;
      last_d <= last_d_nxt;
      memory_valid <= issue_nxt;
      req <= req_nxt;
    end
  // outputs: response steered to the owner, read data broadcast
  always_comb begin
    imemory_ready = state == BUSY && !last_d && memory_ready;
    dmemory_ready = state == BUSY && last_d && memory_ready;
    imemory_rdata = memory_rdata;
    dmemory_rdata = memory_rdata;
    {memory_instr, memory_addr, memory_wdata, memory_wstrb} = req;
  end
  // protocol checks: requests while busy are dropped, responses in IDLE are spurious
  always_ff @(posedge clock)
    if (reset) begin
      assert (!(imemory_valid && !accept_i)) else $warning("mem_arbiter: instruction request while pending ignored");
      assert (!(dmemory_valid && !accept_d)) else $warning("mem_arbiter: data request while pending ignored");
      assert (!(state == IDLE && memory_ready)) else $warning("mem_arbiter: spurious memory ready in IDLE");
    end
endmodule
